servant_btn_debounce: RTL and testbench
=======================================

// Module: servant_btn_debounce
// PURPOSE
//  Conditions raw push-button inputs before they reach the GPIO peripheral's
//  read word. Each button goes through a 2-flop synchroniser and a per-button
//  debounce FSM with a stability counter.
//  Outputs: a clean debounced level bus (drives the GPIO 'buttons' input) and
//  one-cycle press/release strobes. An optional sticky event latch provides an
//  interrupt request.
// PARAMETERS
//  N_BTN            3     number of buttons
//  DEBOUNCE_CYCLES  50000 consecutive stable synchronised samples needed to
//                         accept a new level; must be >= 2
//  CNT_W            16    counter width; must hold DEBOUNCE_CYCLES
// PORTS
//  i_wb_clk       in   1      system clock (shared with the Wishbone fabric)
//  i_wb_rst       in   1      synchronous reset, active-high
//  i_buttons      in   N_BTN  raw, asynchronous, bouncing button inputs (1 = pressed)
//  o_buttons      out  N_BTN  debounced level, to GPIO read path
//  o_press        out  N_BTN  1-cycle strobe on accepted 0->1 transition
//  o_release      out  N_BTN  1-cycle strobe on accepted 1->0 transition
//  i_clr_event    in   N_BTN  per-button clear mask for o_event
//  o_event        out  N_BTN  sticky press flags (optional feature)
//  o_irq          out  1      OR of o_event (optional feature)
// BEHAVIOUR
//  - Sync: s1 <= i_buttons; s2 <= s1. Both registers reset to 0.
//    The FSM consumes s2 only.
//  - Per-button FSM, states STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO; counter cnt:
//    STABLE_LO: s2=1 -> WAIT_HI, cnt<=1; else stay.
//    WAIT_HI:   s2=0 -> STABLE_LO, cnt<=0 (bounce abort, no strobe);
//               else cnt==DEBOUNCE_CYCLES -> STABLE_HI, o_buttons[i]<=1,
//               o_press[i]<=1, cnt<=0; else cnt<=cnt+1.
//    STABLE_HI / WAIT_LO: mirror image with polarity swapped. The WAIT_LO
//               exit drives o_buttons[i]<=0 and o_release[i]<=1.
//  - Latency: i_buttons[i] rises before edge k and stays high ->
//    o_buttons[i] and o_press[i] become 1 after edge k+DEBOUNCE_CYCLES+2.
//    Release is symmetric.
//  - o_press and o_release are registered and high for exactly one cycle.
//    They are never asserted together for the same button.
//  - Counter never wraps. It stops at DEBOUNCE_CYCLES because the FSM leaves
//    the WAIT state there.
//  - Buttons are fully independent. Simultaneous transitions on several
//    buttons produce simultaneous strobes.
//  - Reset (any time, including mid-WAIT): all FSMs go to STABLE_LO; cnt,
//    s1, s2, o_buttons, o_press, o_release, o_event and o_irq all go to 0.
//  - A button held through reset release is debounced as a fresh press and
//    produces one o_press strobe.
// CONFIGURATION
//  Macro SERVANT_BTN_LATCH_EN:
//  - Defined:
//    o_event[i] <= 1 on o_press[i]. Same-cycle condition as the strobe
//    register, so o_event is visible together with o_press.
//    Cleared on i_clr_event[i]=1; set wins over a simultaneous clear.
//    o_irq is registered: it is the OR of o_event, one cycle after o_event.
//  - Undefined:
//    o_event and o_irq are tied to 0; i_clr_event is ignored.
//  Debounce path is identical in both builds.
// TESTING (DEBOUNCE_CYCLES=4)
//  1. Clean press: i_buttons[0] 0->1 before edge 10, held -> o_buttons[0]=1
//     and o_press[0]=1 after edge 16; o_press[0]=0 after edge 17.
//  2. Bounce: i_buttons[1] toggles 1,0,1,0 every 2 cycles, then settles 0
//     -> o_buttons[1] stays 0; no o_press or o_release ever.
//  3. Release: button 2 is stable high, i_buttons[2] 1->0 held ->
//     o_buttons[2]=0 and one o_release[2] pulse, DEBOUNCE_CYCLES+2 cycles after.
//  4. Parallel: buttons 0 and 2 rise on the same cycle -> o_press=3'b101 for
//     one cycle; button 1 unaffected.
//  5. Reset mid-WAIT_HI (cnt=3): assert i_wb_rst for 1 cycle -> all outputs 0;
//     with input still high, the press is accepted DEBOUNCE_CYCLES+2 cycles
//     after reset release.
//  6. LATCH_EN: press button 1 -> o_event=3'b010, o_irq=1 next cycle.
//     Clear coinciding with a new press -> o_event[1] stays 1.
//     Clear alone -> o_event=0 and o_irq=0 one cycle later.
//     Undefined build: o_event=0 and o_irq=0 throughout.

Source files
------------

// File: rtl/servant_btn_debounce.sv
// servant_btn_debounce
//   Conditions raw push-button inputs for the GPIO read word. Each button
//   gets a 2-flop synchroniser and a debounce FSM with a stability counter.
//   A new level is accepted only after DEBOUNCE_CYCLES consecutive
//   synchronised samples at that level.
//
//   Optional feature: macro SERVANT_BTN_LATCH_EN enables sticky per-button
//   press flags (o_event) and a registered interrupt request (o_irq). When
//   the macro is undefined, o_event/o_irq are tied to 0 and i_clr_event is
//   ignored. The debounce path is the same in both builds.
//
// Ports
//   i_wb_clk     system clock
//   i_wb_rst     synchronous reset, active-high
//   i_buttons    raw asynchronous button inputs (1 = pressed)
//   o_buttons    debounced level
//   o_press      1-cycle strobe on an accepted 0->1 transition
//   o_release    1-cycle strobe on an accepted 1->0 transition
//   i_clr_event  per-button clear mask for o_event
//   o_event      sticky press flags (latch build only)
//   o_irq        OR of o_event, one cycle later (latch build only)

// Per-button synchroniser + debounce FSM.
//   press_set is the next-state value of the press strobe, so a consumer can
//   register something in the same cycle the strobe itself is registered.
module servant_btn_debounce_lane #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press,
  output logic rel,
  output logic press_set
);
  typedef enum logic [1:0] {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             s1_q, s2_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    case (state_q)
      STABLE_LO: if (s2_q) begin
        state_d = WAIT_HI;
        cnt_d   = CNT_ONE;
      end
      WAIT_HI: begin
        if (!s2_q) begin
          // bounce: abandon the candidate level without a strobe
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = STABLE_HI;
          level_d = 1'b1;
          press_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE_HI: if (!s2_q) begin
        state_d = WAIT_LO;
        cnt_d   = CNT_ONE;
      end
      WAIT_LO: begin
        if (s2_q) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = STABLE_LO;
          level_d = 1'b0;
          rel_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      s1_q    <= btn_raw;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign level     = level_q;
  assign press     = press_q;
  assign rel       = rel_q;
  assign press_set = press_d;
endmodule

module servant_btn_debounce #(
  parameter int N_BTN           = 3,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic             i_wb_clk,
  input  logic             i_wb_rst,
  input  logic [N_BTN-1:0] i_buttons,
  output logic [N_BTN-1:0] o_buttons,
  output logic [N_BTN-1:0] o_press,
  output logic [N_BTN-1:0] o_release,
  input  logic [N_BTN-1:0] i_clr_event,
  output logic [N_BTN-1:0] o_event,
  output logic             o_irq
);
  logic [N_BTN-1:0] press_set;

  servant_btn_debounce_lane #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_lane [N_BTN-1:0] (
    .clk      (i_wb_clk),
    .rst      (i_wb_rst),
    .btn_raw  (i_buttons),
    .level    (o_buttons),
    .press    (o_press),
    .rel      (o_release),
    .press_set(press_set)
  );

`ifdef SERVANT_BTN_LATCH_EN
  logic [N_BTN-1:0] event_q, event_d;
  logic             irq_q, irq_d;

  always_comb begin
    // set has priority over a clear arriving in the same cycle
    event_d = (event_q & ~i_clr_event) | press_set;
    irq_d   = |event_q;
  end

  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      event_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      event_q <= event_d;
      irq_q   <= irq_d;
    end
  end

  assign o_event = event_q;
  assign o_irq   = irq_q;
`else
  logic unused_evt;
  assign unused_evt = ^{i_clr_event, press_set};
  assign o_event    = '0;
  assign o_irq      = 1'b0;
`endif
endmodule

// File: tb/tb_servant_btn_debounce.sv
module tb_servant_btn_debounce;
  localparam int D = 4;
`ifdef SERVANT_BTN_LATCH_EN
  localparam logic LATCH = 1'b1;
`else
  localparam logic LATCH = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] btn = '0;
  logic [2:0] clr = '0;
  logic [2:0] o_buttons, o_press, o_release, o_event;
  logic       o_irq;

  servant_btn_debounce #(.N_BTN(3), .DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
    .i_wb_clk   (clk),
    .i_wb_rst   (rst),
    .i_buttons  (btn),
    .o_buttons  (o_buttons),
    .o_press    (o_press),
    .o_release  (o_release),
    .i_clr_event(clr),
    .o_event    (o_event),
    .o_irq      (o_irq)
  );

  always #5 clk = ~clk;

  // Row: drive {rst,btn,clr}, expect outputs 'off' cycles later, then hold.
  typedef struct {
    logic rst; logic [2:0] btn; logic [2:0] clr; int hold; int off;
    logic [2:0] lvl; logic [2:0] prs; logic [2:0] rel;
    bit cev; logic [2:0] ev; logic irq;
  } vec_t;
  typedef struct {
    int due; int row;
    logic [2:0] lvl; logic [2:0] prs; logic [2:0] rel;
    bit cev; logic [2:0] ev; logic irq;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   prs_cnt[3];
  int   rel_cnt[3];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic add(input logic r, input logic [2:0] b, input logic [2:0] c,
                     input int h, input int o, input logic [2:0] l,
                     input logic [2:0] p, input logic [2:0] rl, input bit ce,
                     input logic [2:0] e, input logic q);
    vec_t v;
    v.rst = r; v.btn = b; v.clr = c; v.hold = h; v.off = o;
    v.lvl = l; v.prs = p; v.rel = rl; v.cev = ce;
    v.ev = e & {3{LATCH}}; v.irq = q & LATCH;
    tbl.push_back(v);
  endtask

  task automatic chk3(input string nm, input int row, input logic [2:0] act,
                      input logic [2:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d cyc %0d: got %b expected %b", nm, row, cyc, act, exp);
    end
  endtask

  // Scoreboard: compare every entry that falls due this cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (o_press[i] === 1'b1) prs_cnt[i]++;
      if (o_release[i] === 1'b1) rel_cnt[i]++;
    end
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        chk3("o_buttons", sb[i].row, o_buttons, sb[i].lvl);
        chk3("o_press", sb[i].row, o_press, sb[i].prs);
        chk3("o_release", sb[i].row, o_release, sb[i].rel);
        if (sb[i].cev) begin
          chk3("o_event", sb[i].row, o_event, sb[i].ev);
          chk3("o_irq", sb[i].row, {2'b00, o_irq}, {2'b00, sb[i].irq});
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin prs_cnt[i] = 0; rel_cnt[i] = 0; end
    // reset state
    add(1, 3'b000, 3'b000, 3, 1, 3'b000, 3'b000, 3'b000, 1, 3'b000, 0);
    add(0, 3'b000, 3'b000, 5, 4, 3'b000, 3'b000, 3'b000, 1, 3'b000, 0);
    // clean press on button 0: accepted D+3 cycles after drive
    add(0, 3'b001, 3'b000, 0, 6, 3'b000, 3'b000, 3'b000, 0, 3'b000, 0);
    add(0, 3'b001, 3'b000, 0, 7, 3'b001, 3'b001, 3'b000, 1, 3'b001, 0);
    add(0, 3'b001, 3'b000, 12, 8, 3'b001, 3'b000, 3'b000, 1, 3'b001, 1);
    // bounce on button 1
    add(0, 3'b011, 3'b000, 2, 1, 3'b001, 3'b000, 3'b000, 0, 3'b000, 0);
    add(0, 3'b001, 3'b000, 2, 1, 3'b001, 3'b000, 3'b000, 0, 3'b000, 0);
    add(0, 3'b011, 3'b000, 2, 1, 3'b001, 3'b000, 3'b000, 0, 3'b000, 0);
    add(0, 3'b001, 3'b000, 0, 3, 3'b001, 3'b000, 3'b000, 0, 3'b000, 0);
    add(0, 3'b001, 3'b000, 12, 10, 3'b001, 3'b000, 3'b000, 0, 3'b000, 0);
    // button 2 press, then release
    add(0, 3'b101, 3'b000, 0, 7, 3'b101, 3'b100, 3'b000, 1, 3'b101, 1);
    add(0, 3'b101, 3'b000, 12, 8, 3'b101, 3'b000, 3'b000, 0, 3'b000, 0);
    add(0, 3'b001, 3'b000, 0, 6, 3'b101, 3'b000, 3'b000, 0, 3'b000, 0);
    add(0, 3'b001, 3'b000, 0, 7, 3'b001, 3'b000, 3'b100, 1, 3'b101, 1);
    add(0, 3'b001, 3'b000, 12, 8, 3'b001, 3'b000, 3'b000, 0, 3'b000, 0);
    // parallel press of buttons 0 and 2
    add(0, 3'b000, 3'b000, 0, 7, 3'b000, 3'b000, 3'b001, 0, 3'b000, 0);
    add(0, 3'b000, 3'b000, 12, 8, 3'b000, 3'b000, 3'b000, 0, 3'b000, 0);
    add(0, 3'b101, 3'b000, 0, 6, 3'b000, 3'b000, 3'b000, 0, 3'b000, 0);
    add(0, 3'b101, 3'b000, 0, 7, 3'b101, 3'b101, 3'b000, 0, 3'b000, 0);
    add(0, 3'b101, 3'b000, 12, 8, 3'b101, 3'b000, 3'b000, 0, 3'b000, 0);
    // reset while button 1 is in WAIT_HI with cnt=3, button 2 stable high
    add(0, 3'b100, 3'b000, 0, 7, 3'b100, 3'b000, 3'b001, 0, 3'b000, 0);
    add(0, 3'b100, 3'b000, 12, -1, 3'b000, 3'b000, 3'b000, 0, 3'b000, 0);
    add(0, 3'b110, 3'b000, 5, -1, 3'b000, 3'b000, 3'b000, 0, 3'b000, 0);
    add(1, 3'b110, 3'b000, 1, 1, 3'b000, 3'b000, 3'b000, 1, 3'b000, 0);
    add(0, 3'b110, 3'b000, 0, 6, 3'b000, 3'b000, 3'b000, 1, 3'b000, 0);
    add(0, 3'b110, 3'b000, 0, 7, 3'b110, 3'b110, 3'b000, 1, 3'b110, 0);
    add(0, 3'b110, 3'b000, 12, 8, 3'b110, 3'b000, 3'b000, 1, 3'b110, 1);
    // clear all events: o_event drops, o_irq one cycle later
    add(0, 3'b110, 3'b111, 1, 1, 3'b110, 3'b000, 3'b000, 1, 3'b000, 1);
    add(0, 3'b110, 3'b000, 0, 1, 3'b110, 3'b000, 3'b000, 1, 3'b000, 0);
    add(0, 3'b110, 3'b000, 3, -1, 3'b000, 3'b000, 3'b000, 0, 3'b000, 0);
    // button 1 release and press -> event 010, irq next cycle
    add(0, 3'b100, 3'b000, 0, 7, 3'b100, 3'b000, 3'b010, 1, 3'b000, 0);
    add(0, 3'b100, 3'b000, 12, -1, 3'b000, 3'b000, 3'b000, 0, 3'b000, 0);
    add(0, 3'b110, 3'b000, 0, 7, 3'b110, 3'b010, 3'b000, 1, 3'b010, 0);
    add(0, 3'b110, 3'b000, 12, 8, 3'b110, 3'b000, 3'b000, 1, 3'b010, 1);
    // release, then a clear on its own
    add(0, 3'b100, 3'b000, 12, 7, 3'b100, 3'b000, 3'b010, 1, 3'b010, 1);
    add(0, 3'b100, 3'b010, 1, 1, 3'b100, 3'b000, 3'b000, 1, 3'b000, 1);
    add(0, 3'b100, 3'b000, 0, 1, 3'b100, 3'b000, 3'b000, 1, 3'b000, 0);
    add(0, 3'b100, 3'b000, 3, -1, 3'b000, 3'b000, 3'b000, 0, 3'b000, 0);
    // clear landing on the same edge as a new press: set wins
    add(0, 3'b110, 3'b000, 6, -1, 3'b000, 3'b000, 3'b000, 0, 3'b000, 0);
    add(0, 3'b110, 3'b010, 1, 1, 3'b110, 3'b010, 3'b000, 1, 3'b010, 0);
    add(0, 3'b110, 3'b000, 0, 1, 3'b110, 3'b000, 3'b000, 1, 3'b010, 1);
    add(0, 3'b110, 3'b000, 8, -1, 3'b000, 3'b000, 3'b000, 0, 3'b000, 0);

    for (int r = 0; r < tbl.size(); r++) begin
      rst = tbl[r].rst; btn = tbl[r].btn; clr = tbl[r].clr;
      if (tbl[r].off > 0) begin
        e.due = cyc + tbl[r].off; e.row = r;
        e.lvl = tbl[r].lvl; e.prs = tbl[r].prs; e.rel = tbl[r].rel;
        e.cev = tbl[r].cev; e.ev = tbl[r].ev; e.irq = tbl[r].irq;
        sb.push_back(e);
      end
      repeat (tbl[r].hold) begin @(posedge clk); #1; end
    end
    repeat (12) @(posedge clk);
    #1;

    // every queued expectation must have fallen due
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    // total strobe counts catch any spurious pulse between checkpoints
    chk3("press_count_b0", -1, 3'(prs_cnt[0]), 3'd2);
    chk3("press_count_b1", -1, 3'(prs_cnt[1]), 3'd3);
    chk3("press_count_b2", -1, 3'(prs_cnt[2]), 3'd3);
    chk3("release_count_b0", -1, 3'(rel_cnt[0]), 3'd2);
    chk3("release_count_b1", -1, 3'(rel_cnt[1]), 3'd2);
    chk3("release_count_b2", -1, 3'(rel_cnt[2]), 3'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
